// File: rtl/palette_bank_ram_if.sv
// Bundle of the lookup, loader and frame-sync signals of the palette RAM.
// The pixel pipeline is the master and the palette RAM is the slave.
interface palette_bank_ram_if #(
    parameter int INDEX_W   = 4,
    parameter int NUM_BANKS = 16,
    parameter int COLOR_W   = 8
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                   frame_start;
    logic [BANK_W-1:0]      bank_sel;
    logic [2:0]             dim_shift;
    logic                   rd_valid;
    logic [INDEX_W-1:0]     rd_index;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_index;
    logic [3*COLOR_W-1:0]   wr_rgb;
    logic                   busy;
    logic                   out_valid;
    logic [COLOR_W-1:0]     Red;
    logic [COLOR_W-1:0]     Green;
    logic [COLOR_W-1:0]     Blue;
    logic                   Transparent;

    modport master (
        output frame_start, bank_sel, dim_shift, rd_valid, rd_index,
               wr_valid, wr_bank, wr_index, wr_rgb,
        input  wr_ready, busy, out_valid, Red, Green, Blue, Transparent
    );

    modport slave (
        input  frame_start, bank_sel, dim_shift, rd_valid, rd_index,
               wr_valid, wr_bank, wr_index, wr_rgb,
        output wr_ready, busy, out_valid, Red, Green, Blue, Transparent
    );
endinterface

// File: rtl/palette_bank_ram.sv
// Runtime-loadable multi-bank palette: {bank, index} -> RGB through a 2-stage
// pipeline, with a frame-synchronous bank/dim shadow and a transparency flag.
module palette_bank_ram #(
    parameter int                  INDEX_W         = 4,
    parameter int                  NUM_BANKS       = 16,
    parameter int                  COLOR_W         = 8,
    parameter logic [3*COLOR_W-1:0] DEFAULT_RGB    = 24'h800080,
    parameter int                  TRANSPARENT_IDX = 0
) (
    input logic               Clk,
    input logic               Reset_n,
    palette_bank_ram_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ADDR_W = BANK_W + INDEX_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int RGB_W  = 3 * COLOR_W;
    localparam int LAST   = NUM_BANKS * (2 ** INDEX_W) - 1;

    typedef enum logic {S_INIT, S_IDLE} state_t;

    // Logical right shift with zero fill; shifts of a full channel or more clear it.
    function automatic logic [COLOR_W-1:0] dim_channel(input logic [COLOR_W-1:0] c,
                                                       input logic [2:0]         sh);
        if (int'(sh) >= COLOR_W) return '0;
        return c >> sh;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [RGB_W-1:0]    mem_wdata;
    logic                busy, wr_ready;

    logic [RGB_W-1:0]    mem [DEPTH];

    logic [BANK_W-1:0]   shadow_bank;
    logic [2:0]          shadow_dim;

    logic                rd_fire;
    logic                vld_p1;
    logic [RGB_W-1:0]    rdata_p1;
    logic [INDEX_W-1:0]  index_p1;
    logic [2:0]          dim_p1;

    logic                vld_p2;
    logic [COLOR_W-1:0]  red_p2, green_p2, blue_p2;
    logic                transp_p2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        busy       = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {bus.wr_bank, bus.wr_index};
        mem_wdata  = bus.wr_rgb;
        case (state_q)
            S_INIT: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = init_cnt_q;
                mem_wdata  = DEFAULT_RGB;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == ADDR_W'(LAST)) state_d = S_IDLE;
            end
            S_IDLE: begin
                wr_ready = 1'b1;
                mem_we   = bus.wr_valid;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.busy     = busy;
    assign bus.wr_ready = wr_ready;
    assign rd_fire      = bus.rd_valid && (state_q == S_IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_bank <= '0;
            shadow_dim  <= '0;
        end else if (bus.frame_start) begin
            shadow_bank <= bus.bank_sel;
            shadow_dim  <= bus.dim_shift;
        end
    end

    // Stage 1: storage read uses the pre-write word, so a same-cycle write is not visible.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rdata_p1 <= mem[{shadow_bank, bus.rd_index}];
        index_p1 <= bus.rd_index;
        dim_p1   <= shadow_dim;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) vld_p1 <= 1'b0;
        else          vld_p1 <= rd_fire;
    end

    // Stage 2: dim and transparency; outputs hold their value between results.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p2    <= 1'b0;
            red_p2    <= '0;
            green_p2  <= '0;
            blue_p2   <= '0;
            transp_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                red_p2    <= dim_channel(rdata_p1[RGB_W-1 -: COLOR_W], dim_p1);
                green_p2  <= dim_channel(rdata_p1[2*COLOR_W-1 -: COLOR_W], dim_p1);
                blue_p2   <= dim_channel(rdata_p1[COLOR_W-1:0], dim_p1);
                transp_p2 <= (index_p1 == INDEX_W'(TRANSPARENT_IDX));
            end
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.Red         = red_p2;
    assign bus.Green       = green_p2;
    assign bus.Blue        = blue_p2;
    assign bus.Transparent = transp_p2;
endmodule

// File: tb/tb_palette_bank_ram.sv
// Bench for palette_bank_ram: table of lookups plus hand-written corner sequences,
// with a latency-exact scoreboard watching the output stage.
module tb_palette_bank_ram;
    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    palette_bank_ram_if #(.INDEX_W(4), .NUM_BANKS(16), .COLOR_W(8)) bus ();

    palette_bank_ram #(
        .INDEX_W(4), .NUM_BANKS(16), .COLOR_W(8),
        .DEFAULT_RGB(24'h800080), .TRANSPARENT_IDX(0)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        t;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    typedef struct {
        logic [3:0]  bank;
        logic [2:0]  dim;
        logic [3:0]  idx;
        logic        wr;
        logic [23:0] wrgb;
        logic [23:0] exp_rgb;
        logic        exp_t_flag;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Output monitor: each result must appear exactly two cycles after its request.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid cycle %0d: rgb %h with no pending request",
                             cyc, {bus.Red, bus.Green, bus.Blue});
                end else begin
                    me = sb.pop_front();
                    if ({bus.Red, bus.Green, bus.Blue} !== me.rgb || bus.Transparent !== me.t ||
                        cyc != me.cyc) begin
                        errors++;
                        $display("FAIL lookup cycle %0d: got rgb=%h t=%b, expected rgb=%h t=%b at cycle %0d",
                                 cyc, {bus.Red, bus.Green, bus.Blue}, bus.Transparent,
                                 me.rgb, me.t, me.cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_out_valid cycle %0d: out_valid 0, expected rgb=%h", cyc, sb[0].rgb);
                void'(sb.pop_front());
            end
        end
    end

    task automatic clear_inputs();
        bus.frame_start = 1'b0; bus.bank_sel = '0; bus.dim_shift = '0;
        bus.rd_valid = 1'b0; bus.rd_index = '0;
        bus.wr_valid = 1'b0; bus.wr_bank = '0; bus.wr_index = '0; bus.wr_rgb = '0;
    endtask

    task automatic sync();
        @(posedge Clk); #1;
    endtask

    task automatic cycle(input logic fs, input logic [3:0] bsel, input logic [2:0] dim,
                         input logic rv, input logic [3:0] ridx,
                         input logic wv, input logic [3:0] wb, input logic [3:0] wi,
                         input logic [23:0] wrgb, input logic [23:0] erg, input logic et);
        exp_t e;
        bus.frame_start = fs; bus.bank_sel = bsel; bus.dim_shift = dim;
        bus.rd_valid = rv; bus.rd_index = ridx;
        bus.wr_valid = wv; bus.wr_bank = wb; bus.wr_index = wi; bus.wr_rgb = wrgb;
        if (rv) begin
            e.cyc = cyc + 2; e.rgb = erg; e.t = et;
            sb.push_back(e);
        end
        sync();
        clear_inputs();
    endtask

    task automatic wr(input logic [3:0] b, input logic [3:0] i, input logic [23:0] rgb);
        cycle(0, 0, 0, 0, 0, 1, b, i, rgb, 0, 0);
    endtask
    task automatic fs(input logic [3:0] b, input logic [2:0] d);
        cycle(1, b, d, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rd(input logic [3:0] i, input logic [23:0] erg, input logic et);
        cycle(0, 0, 0, 1, i, 0, 0, 0, 0, erg, et);
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) sync();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge Clk);
            if (bus.busy === 1'b1) n++;
            else break;
        end
    endtask

    int n;

    initial begin
        vecs[0] = '{4'd0,  3'd0, 4'd0,  1'b0, 24'h000000, 24'h800080, 1'b1};
        vecs[1] = '{4'd0,  3'd0, 4'd9,  1'b0, 24'h000000, 24'h800080, 1'b0};
        vecs[2] = '{4'd15, 3'd0, 4'd15, 1'b0, 24'h000000, 24'h800080, 1'b0};
        vecs[3] = '{4'd2,  3'd0, 4'd5,  1'b1, 24'h73F705, 24'h73F705, 1'b0};
        vecs[4] = '{4'd2,  3'd2, 4'd5,  1'b0, 24'h000000, 24'h1C3D01, 1'b0};
        vecs[5] = '{4'd2,  3'd7, 4'd5,  1'b0, 24'h000000, 24'h000100, 1'b0};
        vecs[6] = '{4'd7,  3'd1, 4'd0,  1'b1, 24'hA0B0C1, 24'h505860, 1'b1};
        vecs[7] = '{4'd7,  3'd4, 4'd0,  1'b0, 24'h000000, 24'h0A0B0C, 1'b1};
        vecs[8] = '{4'd15, 3'd3, 4'd15, 1'b1, 24'hFFFFFF, 24'h1F1F1F, 1'b0};

        clear_inputs();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_busy", 32'(bus.busy), 32'd1);
        chk("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h0);
        chk("reset_transparent", 32'(bus.Transparent), 32'd0);

        sync();
        Reset_n = 1'b1;
        count_busy(n);
        chk("init_busy_cycles", 32'(n), 32'd256);
        chk("idle_wr_ready", 32'(bus.wr_ready), 32'd1);
        sync();

        foreach (vecs[v]) begin
            if (vecs[v].wr) wr(vecs[v].bank, vecs[v].idx, vecs[v].wrgb);
            fs(vecs[v].bank, vecs[v].dim);
            rd(vecs[v].idx, vecs[v].exp_rgb, vecs[v].exp_t_flag);
            idle(3);
        end

        @(negedge Clk);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h1F1F1F);
        sync();

        // Read-before-write collision, then the new word on the following cycle.
        fs(2, 0);
        cycle(0, 0, 0, 1, 5, 1, 2, 5, 24'h112233, 24'h73F705, 0);
        rd(5, 24'h112233, 0);
        idle(3);

        // A dim change while a request sits in stage 1 must not affect it.
        rd(5, 24'h112233, 0);
        fs(2, 3);
        rd(5, 24'h020406, 0);
        idle(3);
        fs(2, 0);

        // Back-to-back reads with a bank switch coinciding with the middle one.
        wr(2, 1, 24'h010101); wr(2, 2, 24'h020202); wr(2, 3, 24'h232323);
        wr(3, 1, 24'h313131); wr(3, 2, 24'h323232); wr(3, 3, 24'h333333);
        rd(1, 24'h010101, 0);
        cycle(1, 3, 0, 1, 2, 0, 0, 0, 0, 24'h020202, 0);
        rd(3, 24'h333333, 0);
        idle(4);

        // Reset with a request in flight drops it.
        rd(5, 24'h000000, 0);
        Reset_n = 1'b0;
        sb.delete();
        @(negedge Clk);
        chk("reset_drop_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_drop_busy", 32'(bus.busy), 32'd1);
        sync();
        sync();
        Reset_n = 1'b1;
        idle(100);
        chk("mid_init_busy", 32'(bus.busy), 32'd1);
        Reset_n = 1'b0;
        idle(2);
        Reset_n = 1'b1;

        // Writes and reads during init are ignored; frame_start is still taken.
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge Clk);
            if (bus.busy !== 1'b1) break;
            n++;
            if (n == 200) begin
                bus.wr_valid = 1'b1; bus.wr_bank = 4'd0; bus.wr_index = 4'd7; bus.wr_rgb = 24'h123456;
                bus.rd_valid = 1'b1; bus.rd_index = 4'd7;
                bus.frame_start = 1'b1; bus.bank_sel = 4'd0; bus.dim_shift = 3'd1;
            end
            if (n == 210) clear_inputs();
        end
        chk("restart_busy_cycles", 32'(n), 32'd256);
        clear_inputs();
        sync();
        rd(7, 24'h400040, 0);
        rd(0, 24'h400040, 1);
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
